// File: rtl/ir_tx_pkg.sv
// ir_tx_pkg: shared definitions for the IR frame transmitter.
//  - ir_state_e      : frame FSM states
//  - DEF_*           : default timing/size values (100 MHz clock)
//  - ir_max          : larger of two values (used to size the shared timer)
//  - ir_timer_width  : counter width able to hold 0..max_cyc
package ir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD_M = 3'd1,
    ST_LEAD_S = 3'd2,
    ST_BIT_M  = 3'd3,
    ST_BIT_S  = 3'd4,
    ST_LINK_M = 3'd5,
    ST_LINK_S = 3'd6,
    ST_STOP_M = 3'd7
  } ir_state_e;

  localparam int unsigned DEF_SEG0_BITS      = 32'd35;
  localparam int unsigned DEF_SEG1_BITS      = 32'd32;
  localparam int unsigned DEF_LEAD_MARK_CYC  = 32'd900000;
  localparam int unsigned DEF_LEAD_SPACE_CYC = 32'd450000;
  localparam int unsigned DEF_BIT_MARK_CYC   = 32'd56000;
  localparam int unsigned DEF_ZERO_SPACE_CYC = 32'd56000;
  localparam int unsigned DEF_ONE_SPACE_CYC  = 32'd168000;
  localparam int unsigned DEF_LINK_MARK_CYC  = 32'd56000;
  localparam int unsigned DEF_LINK_SPACE_CYC = 32'd2000000;
  localparam int unsigned DEF_CARRIER_DIV    = 32'd2632;

  function automatic int unsigned ir_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned ir_timer_width(input int unsigned max_cyc);
    return $clog2(max_cyc + 32'd1);
  endfunction

endpackage

// File: rtl/ir_seg_timer.sv
// ir_seg_timer: loadable down-counter shared by all frame states.
//  clk, rst    clock / asynchronous active-low reset
//  load        load load_val this cycle (takes priority over counting)
//  load_val    value loaded; a state of N cycles is loaded with N-1
//  value       current count
//  expire      count is zero (last cycle of the current state)
module ir_seg_timer #(
  parameter int unsigned W = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value  = cnt_r;
  assign expire = (cnt_r == '0);

endmodule

// File: rtl/ir_frame_tx.sv
// ir_frame_tx: IR remote frame transmitter.
//  Frame = lead code + SEG0 bits + [link code + SEG1 bits] + stop mark, MSB first.
//  Ports:
//   clk, rst    clock / asynchronous active-low reset
//   tx_valid    frame request; accepted on tx_valid && tx_ready
//   tx_ready    high only while idle
//   seg0_data   segment 0 payload (SEG0_BITS)
//   seg1_data   segment 1 payload (max(SEG1_BITS,1)); ignored when SEG1_BITS == 0
//   abort       cancel the frame in progress (ignored while idle)
//   ir_out      registered IR LED drive
//   busy        frame in progress (~tx_ready)
//   done        one-cycle pulse on normal frame completion
//  Build option: define IR_TX_CARRIER_EN to gate the envelope with an internal
//  carrier of CARRIER_DIV clocks (high for the first half of each period).
module ir_frame_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned SEG0_BITS      = DEF_SEG0_BITS,
  parameter int unsigned SEG1_BITS      = DEF_SEG1_BITS,
  parameter int unsigned LEAD_MARK_CYC  = DEF_LEAD_MARK_CYC,
  parameter int unsigned LEAD_SPACE_CYC = DEF_LEAD_SPACE_CYC,
  parameter int unsigned BIT_MARK_CYC   = DEF_BIT_MARK_CYC,
  parameter int unsigned ZERO_SPACE_CYC = DEF_ZERO_SPACE_CYC,
  parameter int unsigned ONE_SPACE_CYC  = DEF_ONE_SPACE_CYC,
  parameter int unsigned LINK_MARK_CYC  = DEF_LINK_MARK_CYC,
  parameter int unsigned LINK_SPACE_CYC = DEF_LINK_SPACE_CYC,
  parameter int unsigned CARRIER_DIV    = DEF_CARRIER_DIV
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       tx_valid,
  output logic                                       tx_ready,
  input  logic [SEG0_BITS-1:0]                       seg0_data,
  input  logic [((SEG1_BITS > 0) ? SEG1_BITS : 1)-1:0] seg1_data,
  input  logic                                       abort,
  output logic                                       ir_out,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned S1W      = (SEG1_BITS > 0) ? SEG1_BITS : 32'd1;
  localparam bit          HAS_SEG1 = (SEG1_BITS != 32'd0);
  localparam int unsigned MAX_CYC  =
    ir_max(ir_max(ir_max(LEAD_MARK_CYC, LEAD_SPACE_CYC), ir_max(BIT_MARK_CYC, ZERO_SPACE_CYC)),
           ir_max(ONE_SPACE_CYC, ir_max(LINK_MARK_CYC, LINK_SPACE_CYC)));
  localparam int unsigned TW  = ir_timer_width(MAX_CYC);
  localparam int unsigned BCW = ir_timer_width(ir_max(SEG0_BITS, S1W));

  // Timer reload values: a state lasting N cycles is loaded with N-1.
  localparam logic [TW-1:0] LEAD_M_LD = TW'(LEAD_MARK_CYC - 32'd1);
  localparam logic [TW-1:0] LEAD_S_LD = TW'(LEAD_SPACE_CYC - 32'd1);
  localparam logic [TW-1:0] BIT_M_LD  = TW'(BIT_MARK_CYC - 32'd1);
  localparam logic [TW-1:0] ZERO_LD   = TW'(ZERO_SPACE_CYC - 32'd1);
  localparam logic [TW-1:0] ONE_LD    = TW'(ONE_SPACE_CYC - 32'd1);
  localparam logic [TW-1:0] LINK_M_LD = TW'(LINK_MARK_CYC - 32'd1);
  localparam logic [TW-1:0] LINK_S_LD = TW'(LINK_SPACE_CYC - 32'd1);
  localparam logic [BCW-1:0] BITS0_LD = BCW'(SEG0_BITS - 32'd1);
  localparam logic [BCW-1:0] BITS1_LD = BCW'(S1W - 32'd1);

  ir_state_e         state_r, state_next_s;
  logic [SEG0_BITS-1:0] sh0_r;
  logic [S1W-1:0]    sh1_r;
  logic              seg_sel_r;
  logic [BCW-1:0]    bit_cnt_r;
  logic              ir_out_r, tx_ready_r, busy_r, done_r;

  logic              accept_s, cur_bit_s, bit_end_s;
  logic              tmr_load_s, tmr_expire_s;
  logic [TW-1:0]     tmr_load_val_s, tmr_value_s;
  logic              env_next_s, ir_next_s, ready_next_s, done_next_s;

  assign accept_s  = tx_valid & tx_ready_r;
  assign cur_bit_s = seg_sel_r ? sh1_r[S1W-1] : sh0_r[SEG0_BITS-1];
  assign bit_end_s = (state_r == ST_BIT_S) & tmr_expire_s & ~abort;

  ir_seg_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .value    (tmr_value_s),
    .expire   (tmr_expire_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic: abort wins over timer expiry in any active state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_LEAD_M;
        else          state_next_s = ST_IDLE;
      end
      default: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (!tmr_expire_s) begin
          state_next_s = state_r;
        end else begin
          case (state_r)
            ST_LEAD_M: state_next_s = ST_LEAD_S;
            ST_LEAD_S: state_next_s = ST_BIT_M;
            ST_BIT_M:  state_next_s = ST_BIT_S;
            ST_BIT_S: begin
              if (bit_cnt_r != '0)              state_next_s = ST_BIT_M;
              else if (!seg_sel_r && HAS_SEG1)  state_next_s = ST_LINK_M;
              else                              state_next_s = ST_STOP_M;
            end
            ST_LINK_M: state_next_s = ST_LINK_S;
            ST_LINK_S: state_next_s = ST_BIT_M;
            ST_STOP_M: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // FSM outputs: next-cycle envelope, timer reload on every state change, handshake/done.
  always_comb begin
    env_next_s     = 1'b0;
    tmr_load_val_s = '0;
    tmr_load_s     = (state_next_s != state_r);
    ready_next_s   = (state_next_s == ST_IDLE);
    done_next_s    = (state_r == ST_STOP_M) & tmr_expire_s & ~abort;
    case (state_next_s)
      ST_LEAD_M: begin env_next_s = 1'b1; tmr_load_val_s = LEAD_M_LD; end
      ST_LEAD_S: begin env_next_s = 1'b0; tmr_load_val_s = LEAD_S_LD; end
      ST_BIT_M:  begin env_next_s = 1'b1; tmr_load_val_s = BIT_M_LD;  end
      ST_BIT_S: begin
        env_next_s = 1'b0;
        if (cur_bit_s) tmr_load_val_s = ONE_LD;
        else           tmr_load_val_s = ZERO_LD;
      end
      ST_LINK_M: begin env_next_s = 1'b1; tmr_load_val_s = LINK_M_LD; end
      ST_LINK_S: begin env_next_s = 1'b0; tmr_load_val_s = LINK_S_LD; end
      ST_STOP_M: begin env_next_s = 1'b1; tmr_load_val_s = BIT_M_LD;  end
      default:   begin env_next_s = 1'b0; tmr_load_val_s = '0;        end
    endcase
  end

  // Payload capture on accept; shift out and count bits as each bit space ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh0_r     <= '0;
      sh1_r     <= '0;
      seg_sel_r <= 1'b0;
      bit_cnt_r <= '0;
    end else if (accept_s) begin
      sh0_r     <= seg0_data;
      sh1_r     <= seg1_data;
      seg_sel_r <= 1'b0;
      bit_cnt_r <= BITS0_LD;
    end else if (bit_end_s) begin
      if (bit_cnt_r != '0) begin
        bit_cnt_r <= bit_cnt_r - BCW'(1);
        if (seg_sel_r) sh1_r <= sh1_r << 1'b1;
        else           sh0_r <= sh0_r << 1'b1;
      end else if (!seg_sel_r && HAS_SEG1) begin
        // Segment 0 finished: arm segment 1 for after the link code.
        seg_sel_r <= 1'b1;
        bit_cnt_r <= BITS1_LD;
        sh0_r     <= sh0_r << 1'b1;
      end else begin
        bit_cnt_r <= '0;
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

`ifdef IR_TX_CARRIER_EN
  localparam int unsigned CW = ir_timer_width(CARRIER_DIV);
  logic [CW-1:0] car_cnt_r, car_next_s;

  // Free-running carrier phase, restarted on accept so the first mark starts high.
  always_comb begin
    car_next_s = '0;
    if (accept_s)                                  car_next_s = '0;
    else if (car_cnt_r >= CW'(CARRIER_DIV - 32'd1)) car_next_s = '0;
    else                                           car_next_s = car_cnt_r + CW'(1);
  end

  // Carrier phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_cnt_r <= '0;
    end else begin
      car_cnt_r <= car_next_s;
    end
  end

  assign ir_next_s = env_next_s & (car_next_s < CW'(CARRIER_DIV / 32'd2));
`else
  assign ir_next_s = env_next_s;
`endif

  // Registered outputs, computed from next-cycle values so they align with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_out_r   <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      ir_out_r   <= ir_next_s;
      tx_ready_r <= ready_next_s;
      busy_r     <= ~ready_next_s;
      done_r     <= done_next_s;
    end
  end

  assign ir_out   = ir_out_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ir_frame_tx.sv
// Scoreboard bench for ir_frame_tx: two instances (SEG1_BITS=3 and SEG1_BITS=0)
// with short timings. Stimulus pushes per-cycle expected ir_out/tx_ready/busy/done
// samples; a monitor pops and compares them on the falling edge.
module tb_ir_frame_tx;

  localparam int unsigned S0 = 4, S1 = 3;
  localparam int unsigned LM = 8, LS = 4, BM = 2, ZS = 2, OS = 5, KM = 2, KS = 6, CD = 4;
  localparam int unsigned NOLIM = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic va, ra, aba, ira, bua, doa;
  logic [3:0] s0a;
  logic [2:0] s1a;
  logic vb, rb, abb, irb, bub, dob;
  logic [3:0] s0b;
  logic [0:0] s1b;

  typedef struct {
    int unsigned cyc;
    logic        ir;
    logic        ready;
    logic        done;
  } samp_t;

  samp_t sb_a[$];
  samp_t sb_b[$];

  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int exp_done_a = 0, exp_done_b = 0;

  ir_frame_tx #(
    .SEG0_BITS(S0), .SEG1_BITS(S1), .LEAD_MARK_CYC(LM), .LEAD_SPACE_CYC(LS),
    .BIT_MARK_CYC(BM), .ZERO_SPACE_CYC(ZS), .ONE_SPACE_CYC(OS),
    .LINK_MARK_CYC(KM), .LINK_SPACE_CYC(KS), .CARRIER_DIV(CD)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(va), .tx_ready(ra), .seg0_data(s0a),
    .seg1_data(s1a), .abort(aba), .ir_out(ira), .busy(bua), .done(doa)
  );

  ir_frame_tx #(
    .SEG0_BITS(S0), .SEG1_BITS(0), .LEAD_MARK_CYC(LM), .LEAD_SPACE_CYC(LS),
    .BIT_MARK_CYC(BM), .ZERO_SPACE_CYC(ZS), .ONE_SPACE_CYC(OS),
    .LINK_MARK_CYC(KM), .LINK_SPACE_CYC(KS), .CARRIER_DIV(CD)
  ) dut0 (
    .clk(clk), .rst(rst), .tx_valid(vb), .tx_ready(rb), .seg0_data(s0b),
    .seg1_data(s1b), .abort(abb), .ir_out(irb), .busy(bub), .done(dob)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every expected sample due in this cycle.
  always @(negedge clk) begin
    samp_t s;
    if (doa === 1'b1) done_cnt_a++;
    if (dob === 1'b1) done_cnt_b++;
    while (sb_a.size() > 0 && sb_a[0].cyc < cyc) begin
      s = sb_a.pop_front();
      check($sformatf("a_stale@%0d", s.cyc), 32'd0, 32'd1);
    end
    if (sb_a.size() > 0 && sb_a[0].cyc == cyc) begin
      s = sb_a.pop_front();
      check($sformatf("a_ir@%0d", cyc), {31'd0, ira}, {31'd0, s.ir});
      check($sformatf("a_ready@%0d", cyc), {31'd0, ra}, {31'd0, s.ready});
      check($sformatf("a_busy@%0d", cyc), {31'd0, bua}, {31'd0, ~s.ready});
      check($sformatf("a_done@%0d", cyc), {31'd0, doa}, {31'd0, s.done});
    end
    while (sb_b.size() > 0 && sb_b[0].cyc < cyc) begin
      s = sb_b.pop_front();
      check($sformatf("b_stale@%0d", s.cyc), 32'd0, 32'd1);
    end
    if (sb_b.size() > 0 && sb_b[0].cyc == cyc) begin
      s = sb_b.pop_front();
      check($sformatf("b_ir@%0d", cyc), {31'd0, irb}, {31'd0, s.ir});
      check($sformatf("b_ready@%0d", cyc), {31'd0, rb}, {31'd0, s.ready});
      check($sformatf("b_busy@%0d", cyc), {31'd0, bub}, {31'd0, ~s.ready});
      check($sformatf("b_done@%0d", cyc), {31'd0, dob}, {31'd0, s.done});
    end
  end

  function automatic logic car_exp(input int unsigned c, input int unsigned start);
`ifdef IR_TX_CARRIER_EN
    return (((c - start) % CD) < (CD / 2)) ? 1'b1 : 1'b0;
`else
    return (c >= start) ? 1'b1 : 1'b0;
`endif
  endfunction

  task automatic push_samp(input int u, input int unsigned c, input logic ir,
                           input logic ready, input logic dn, input int unsigned limit);
    samp_t s;
    s.cyc = c; s.ir = ir; s.ready = ready; s.done = dn;
    if (c < limit) begin
      if (u == 0) sb_a.push_back(s);
      else        sb_b.push_back(s);
    end
  endtask

  task automatic push_run(input int u, inout int unsigned c, input int unsigned start,
                          input logic lvl, input int unsigned len, input int unsigned limit);
    for (int i = 0; i < int'(len); i++) begin
      push_samp(u, c, lvl & car_exp(c, start), 1'b0, 1'b0, limit);
      c++;
    end
  endtask

  // Expected waveform of one frame starting (first lead-mark cycle) at 'start'.
  task automatic push_frame(input int u, input int unsigned start, input logic [3:0] d0,
                            input logic [2:0] d1, input int unsigned limit);
    int unsigned c;
    c = start;
    push_run(u, c, start, 1'b1, LM, limit);
    push_run(u, c, start, 1'b0, LS, limit);
    for (int i = 3; i >= 0; i--) begin
      push_run(u, c, start, 1'b1, BM, limit);
      push_run(u, c, start, 1'b0, d0[i] ? OS : ZS, limit);
    end
    if (u == 0) begin
      push_run(u, c, start, 1'b1, KM, limit);
      push_run(u, c, start, 1'b0, KS, limit);
      for (int i = 2; i >= 0; i--) begin
        push_run(u, c, start, 1'b1, BM, limit);
        push_run(u, c, start, 1'b0, d1[i] ? OS : ZS, limit);
      end
    end
    push_run(u, c, start, 1'b1, BM, limit);
    push_samp(u, c, 1'b0, 1'b1, 1'b1, limit);
  endtask

  task automatic expect_idle(input int u, input int n);
    for (int i = 1; i <= n; i++) push_samp(u, cyc + i, 1'b0, 1'b1, 1'b0, NOLIM);
    repeat (n) @(negedge clk);
  endtask

  // Request a frame; returns at #1 after the accepting edge. lim_off truncates expectations.
  task automatic send(input int u, input logic [3:0] d0, input logic [2:0] d1,
                      input int unsigned lim_off, input bit hold, output int unsigned start);
    int w;
    w = 0;
    @(negedge clk);
    if (u == 0) begin va = 1'b1; s0a = d0; s1a = d1; end
    else        begin vb = 1'b1; s0b = d0; s1b = 1'b0; end
    while (((u == 0) ? ra : rb) !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("send_timeout", 32'd0, 32'd1);
    start = cyc + 1;
    push_frame(u, start, d0, d1, (lim_off == NOLIM) ? NOLIM : start + lim_off);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (u == 0) begin va = 1'b0; s0a = 4'h0; s1a = 3'h0; end
      else        begin vb = 1'b0; s0b = 4'h0; end
    end
  endtask

  task automatic drain(input int u);
    int w;
    w = 0;
    while (((u == 0) ? sb_a.size() : sb_b.size()) > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      check("drain_timeout", 32'd0, 32'd1);
      if (u == 0) sb_a.delete();
      else        sb_b.delete();
    end
  endtask

  task automatic wait_cyc(input int unsigned target);
    int w;
    w = 0;
    while (cyc < target && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (cyc != target) check("wait_cyc", cyc, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned st;
    va = 1'b0; s0a = 4'h0; s1a = 3'h0; aba = 1'b0;
    vb = 1'b0; s0b = 4'h0; s1b = 1'b0; abb = 1'b0;
    for (int c = 1; c <= 3; c++) push_samp(0, c, 1'b0, 1'b1, 1'b0, NOLIM);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_idle(0, 3);

    // Basic frame and further patterns on the two-segment instance.
    send(0, 4'b1010, 3'b011, NOLIM, 1'b0, st); exp_done_a++; drain(0);
    send(0, 4'b0000, 3'b000, NOLIM, 1'b0, st); exp_done_a++; drain(0);
    send(0, 4'b1111, 3'b111, NOLIM, 1'b0, st); exp_done_a++; drain(0);

    // Back-to-back: request held high, second frame starts right after done.
    send(0, 4'b0110, 3'b101, NOLIM, 1'b1, st); exp_done_a++;
    send(0, 4'b1001, 3'b010, NOLIM, 1'b0, st); exp_done_a++;
    drain(0);
    expect_idle(0, 2);

    // Abort during the third bit of segment 0 (its mark, frame cycle 24).
    send(0, 4'b1010, 3'b011, 32'd25, 1'b0, st);
    wait_cyc(st + 24);
    aba = 1'b1;
    for (int c = 25; c <= 30; c++) push_samp(0, st + c, 1'b0, 1'b1, 1'b0, NOLIM);
    @(negedge clk);
    aba = 1'b0;
    drain(0);

    // Abort asserted together with the accept: accept wins, full frame follows.
    aba = 1'b1;
    send(0, 4'b1100, 3'b001, NOLIM, 1'b0, st); exp_done_a++;
    aba = 1'b0;
    drain(0);

    // Async reset during the lead mark: ir_out must fall before the next edge.
    send(0, 4'b1010, 3'b011, 32'd4, 1'b0, st);
    wait_cyc(st + 3);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ir", {31'd0, ira}, 32'd0);
    check("rst_async_ready", {31'd0, ra}, 32'd1);
    expect_idle(0, 2);
    rst = 1'b1;
    expect_idle(0, 3);

    // Reset in the middle of the link space, then normal operation.
    send(0, 4'b1010, 3'b011, 32'd39, 1'b0, st);
    wait_cyc(st + 38);
    #2 rst = 1'b0;
    #1;
    check("rst_link_ir", {31'd0, ira}, 32'd0);
    check("rst_link_busy", {31'd0, bua}, 32'd0);
    expect_idle(0, 2);
    rst = 1'b1;
    expect_idle(0, 3);
    send(0, 4'b0101, 3'b110, NOLIM, 1'b0, st); exp_done_a++; drain(0);

    // Single-segment instance: no link code, 42-cycle frame for 4'b1111.
    send(1, 4'b1111, 3'b000, NOLIM, 1'b0, st); exp_done_b++; drain(1);
    send(1, 4'b0110, 3'b000, NOLIM, 1'b0, st); exp_done_b++; drain(1);
    expect_idle(1, 2);

    check("done_count_a", done_cnt_a, exp_done_a);
    check("done_count_b", done_cnt_b, exp_done_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
